sys_mem_ctr: RTL and testbench
==============================

// Module: sys_mem_ctr
// PURPOSE
//  System-bus responder for the cache controller's Sys* interface: accepts a line-fill read or a
//  single-word write-through strobe, applies a fixed access latency, drives a word-serial burst
//  into the cache with the line-complete flag `readup`, and acknowledges writes with SysReady.
//  Sits between the cache and a synchronous single-port main-memory SRAM (1-cycle read latency).
// PARAMETERS
//  ADDR_W     32  byte-address width
//  DATA_W     32  word width
//  LINE_WORDS 4   words per cache line (power of 2, >=2); OFS_W = log2(LINE_WORDS)
//  RD_LAT     3   idle cycles between read strobe and first MemRead (>=1)
//  WR_LAT     2   idle cycles between write strobe and MemWrite (>=1)
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       asynchronous, active-low reset
//  SysStrobe     in   1       1-cycle request pulse from cache
//  SysRW         in   1       `RW_READ / `RW_WRITE, valid with SysStrobe
//  SysAddr       in   ADDR_W  request byte address, valid with SysStrobe
//  SysWData      in   DATA_W  write word, valid with SysStrobe
//  SysReady      out  1       1-cycle write acknowledge
//  SysRData      out  DATA_W  burst read word
//  SysRValid     out  1       SysRData/SysROffset valid this cycle
//  SysROffset    out  OFS_W   word offset of SysRData within line
//  readup        out  1       1-cycle pulse: line fill complete
//  MemAddr       out  ADDR_W  SRAM word-aligned byte address
//  MemRead       out  1       SRAM read enable (data on MemRData next cycle)
//  MemWrite      out  1       SRAM write enable
//  MemWData      out  DATA_W  SRAM write data
//  MemRData      in   DATA_W  SRAM read data
//  ProtoErr      out  1       sticky: strobe received while busy
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; all outputs 0; counters, latches, ProtoErr cleared.
//  - All outputs registered except none; Mem* and Sys* driven from flops.
//  - States: IDLE, RD_WAIT, RD_ISSUE, RD_LAST, RD_DONE, WR_WAIT, WR_DO, WR_DONE.
//  - IDLE: SysStrobe&&SysRW==`RW_READ -> latch line base (SysAddr with low OFS_W+2 bits zeroed),
//    cnt=RD_LAT-1, go RD_WAIT. SysStrobe&&`RW_WRITE -> latch SysAddr (word-aligned) and
//    SysWData, cnt=WR_LAT-1, go WR_WAIT. Else stay.
//  - RD_WAIT: cnt==0 -> RD_ISSUE, issue idx=0; else cnt--.
//  - RD_ISSUE: MemRead=1, MemAddr=base+4*idx each cycle, idx++; at idx==LINE_WORDS-1 -> RD_LAST.
//    Word from MemRead in cycle N appears on SysRData with SysRValid=1, SysROffset=idx in N+1.
//  - RD_LAST: returns final word (SysROffset=LINE_WORDS-1); readup=1 in the SAME cycle; -> RD_DONE.
//  - RD_DONE: 1 cycle, all outputs 0 -> IDLE (cache leaves READSYS on readup, then READDATA).
//  - Read latency: strobe at cycle T -> first SysRValid at T+RD_LAT+2; readup at
//    T+RD_LAT+LINE_WORDS+1; exactly LINE_WORDS consecutive SysRValid pulses, offsets 0..N-1 in order.
//  - WR_WAIT: cnt countdown as RD_WAIT -> WR_DO. WR_DO: MemWrite=1, MemAddr/MemWData = latched,
//    1 cycle -> WR_DONE. WR_DONE: SysReady=1 for 1 cycle -> IDLE.
//    Write latency: strobe at T -> MemWrite at T+WR_LAT+1, SysReady at T+WR_LAT+2.
//  - MemRead and MemWrite never both 1. SysReady and readup never both 1.
//  - Strobe in any non-IDLE state: ignored (no queueing), ProtoErr set, cleared only by reset.
//  - Strobe in the cycle the FSM returns to IDLE (RD_DONE/WR_DONE) is also ignored + ProtoErr;
//    cache protocol guarantees >=1 cycle gap.
//  - Address arithmetic is modulo 2^ADDR_W; burst never crosses the latched line (offset wraps
//    not needed since base is aligned).
//  - reset asserted mid-burst/mid-write: immediate return to IDLE, SysRValid/readup/SysReady/
//    MemRead/MemWrite deasserted asynchronously; partial line is not completed.
// STRUCTURE
//  - Shared defines header (sys_defs.vh): `RW_READ, `RW_WRITE, `RW_UNK, state encodings,
//    shared with cache_ctr.
//  - One sub-module: sys_lat_cnt (loadable down-counter, load/en inputs, zero flag),
//    instantiated once, reused for RD_LAT and WR_LAT.
// TESTING
//  1 Reset: hold reset=0 3 cycles with SysStrobe toggling -> all outputs 0, ProtoErr=0, state IDLE.
//  2 Read fill: SysAddr=0x0000_1234 read, RD_LAT=3 -> MemAddr 0x1230,0x1234,0x1238,0x123C on
//    4 consecutive cycles; SysROffset 0..3 with SRAM data; readup coincides with offset 3, at T+8.
//  3 Write: SysAddr=0x0000_0088, SysWData=0xDEAD_BEEF -> MemWrite=1 at T+3 with that addr/data,
//    SysReady=1 only at T+4; no SysRValid/readup.
//  4 Back-to-back: read then write strobe 1 cycle after RD_DONE -> both complete, ProtoErr=0.
//  5 Busy strobe: second strobe during RD_ISSUE -> ignored, burst unchanged, ProtoErr=1 sticky.
//  6 Reset mid-burst after 2 words -> outputs 0 immediately; next read strobe gives full 4-word fill.

Source files
------------

// File: rtl/sys_mem_ctr_pkg.sv
// Shared definitions for the system-bus memory responder: request
// direction codes, FSM state encoding and a small elaboration helper.
package sys_mem_ctr_pkg;

  // SysRW encodings, shared with the cache controller side of the bus
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_LAST  = 3'd3,
    ST_RD_DONE  = 3'd4,
    ST_WR_WAIT  = 3'd5,
    ST_WR_DO    = 3'd6,
    ST_WR_DONE  = 3'd7
  } state_t;

  // Larger of two latencies, used to size the shared latency counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sys_mem_ctr_lat_cnt.sv
// Loadable down-counter with a zero flag. One instance is shared by the
// read and write paths to time the fixed access latency.
module sys_mem_ctr_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at zero so a stray enable is harmless
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sys_mem_ctr.sv
// System-bus responder between the cache controller and a synchronous
// single-port SRAM. Serves line fills as a word-serial burst and
// single-word write-throughs, each after a fixed access latency.
module sys_mem_ctr
  import sys_mem_ctr_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int LINE_WORDS = 4,
  parameter  int RD_LAT     = 3,
  parameter  int WR_LAT     = 2,
  localparam int OFS_W      = $clog2(LINE_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              SysStrobe,
  input  logic              SysRW,
  input  logic [ADDR_W-1:0] SysAddr,
  input  logic [DATA_W-1:0] SysWData,
  output logic              SysReady,
  output logic [DATA_W-1:0] SysRData,
  output logic              SysRValid,
  output logic [OFS_W-1:0]  SysROffset,
  output logic              readup,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              ProtoErr
);

  localparam int MAX_LAT = max_int(RD_LAT, WR_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0]  RD_CNT    = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  WR_CNT    = CNT_W'(WR_LAT - 1);
  localparam logic [OFS_W-1:0]  LAST_IDX  = OFS_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFS_W-2){1'b1}}, {(OFS_W+2){1'b0}}};
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t             state, state_nxt;
  logic [OFS_W-1:0]   idx, idx_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [DATA_W-1:0]  data_q, data_nxt;
  logic               cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]   cnt_load_val;

  sys_mem_ctr_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // State, burst index and request latches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
    end
  end

  // Next-state logic; strobes outside IDLE are dropped, never queued
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SysStrobe) begin
          cnt_load = 1'b1;
          if (SysRW == RW_READ) begin
            addr_nxt     = SysAddr & LINE_MASK;
            cnt_load_val = RD_CNT;
            state_nxt    = ST_RD_WAIT;
          end else if (SysRW == RW_WRITE) begin
            addr_nxt     = SysAddr & WORD_MASK;
            data_nxt     = SysWData;
            cnt_load_val = WR_CNT;
            state_nxt    = ST_WR_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_zero) begin
          state_nxt = ST_RD_ISSUE;
          idx_nxt   = '0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RD_ISSUE: begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_RD_LAST;
        end else begin
          idx_nxt = idx + OFS_W'(1);
        end
      end
      ST_RD_LAST: state_nxt = ST_RD_DONE;
      ST_RD_DONE: state_nxt = ST_IDLE;
      ST_WR_WAIT: begin
        if (cnt_zero) begin
          state_nxt = ST_WR_DO;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WR_DO:   state_nxt = ST_WR_DONE;
      ST_WR_DONE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // SRAM strobes are registered from the next state so they change cleanly on the edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
    end else begin
      MemRead  <= (state_nxt == ST_RD_ISSUE);
      MemWrite <= (state_nxt == ST_WR_DO);
      if (state_nxt == ST_RD_ISSUE) begin
        MemAddr <= addr_nxt + ADDR_W'({idx_nxt, 2'b00});
      end else if (state_nxt == ST_WR_DO) begin
        MemAddr <= addr_nxt;
      end else begin
        MemAddr <= '0;
      end
      MemWData <= (state_nxt == ST_WR_DO) ? data_nxt : '0;
    end
  end

  // Cache-side handshakes; the read valid/offset trail the SRAM read by its one-cycle latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      SysRValid  <= 1'b0;
      SysROffset <= '0;
      readup     <= 1'b0;
      SysReady   <= 1'b0;
    end else begin
      SysRValid  <= MemRead;
      SysROffset <= MemRead ? idx : '0;
      readup     <= (state_nxt == ST_RD_LAST);
      SysReady   <= (state_nxt == ST_WR_DONE);
    end
  end

  // Sticky protocol error: any request that arrives while a transaction is in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ProtoErr <= 1'b0;
    end else if (SysStrobe && (state != ST_IDLE)) begin
      ProtoErr <= 1'b1;
    end
  end

  // The SRAM output register already provides the pipeline stage, so the
  // returned word is forwarded and gated by the registered valid
  assign SysRData = SysRValid ? MemRData : '0;

endmodule

// File: tb/tb_sys_mem_ctr.sv
// Directed bench for sys_mem_ctr: reset, line fill, write-through,
// back-to-back requests, busy strobe and reset in the middle of a burst.
module tb_sys_mem_ctr;
  import sys_mem_ctr_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        SysStrobe;
  logic        SysRW;
  logic [31:0] SysAddr;
  logic [31:0] SysWData;
  logic        SysReady;
  logic [31:0] SysRData;
  logic        SysRValid;
  logic [1:0]  SysROffset;
  logic        readup;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemWData;
  logic [31:0] MemRData = 32'h0;
  logic        ProtoErr;

  int n_cmp = 0;
  int n_err = 0;

  sys_mem_ctr dut (
    .clock      (clock),
    .reset      (reset),
    .SysStrobe  (SysStrobe),
    .SysRW      (SysRW),
    .SysAddr    (SysAddr),
    .SysWData   (SysWData),
    .SysReady   (SysReady),
    .SysRData   (SysRData),
    .SysRValid  (SysRValid),
    .SysROffset (SysROffset),
    .readup     (readup),
    .MemAddr    (MemAddr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemWData   (MemWData),
    .MemRData   (MemRData),
    .ProtoErr   (ProtoErr)
  );

  always #5 clock = ~clock;

  // SRAM model: one-cycle read latency, content is a fixed function of the address
  always @(posedge clock) begin
    if (MemRead) MemRData <= 32'hC0DE_0000 ^ MemAddr;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    SysStrobe = 1'b1;
    SysRW     = rw;
    SysAddr   = addr;
    SysWData  = wdata;
    tick();
    SysStrobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [135:0] all_out;
    reset = 1'b0;
    SysRW = RW_READ;
    SysAddr = 32'h0000_1234;
    SysWData = 32'h0;
    SysStrobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SysStrobe = ~SysStrobe;
      tick();
    end
    all_out = {SysReady, SysRValid, readup, MemRead, MemWrite, ProtoErr,
               SysROffset, SysRData, MemAddr, MemWData, 32'h0};
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs got %h want 0", all_out);
    end
    SysStrobe = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({MemRead, MemWrite, SysRValid, ProtoErr} !== 4'b0) begin
        n_err++;
        $display("[TB] FAIL reset_idle got %b want 0000", {MemRead, MemWrite, SysRValid, ProtoErr});
      end
    end
  endtask

  task automatic test_read_fill(input logic [31:0] addr, input logic [31:0] base);
    logic        e_rd, e_val, e_up;
    logic [31:0] e_addr, e_data;
    logic [1:0]  e_ofs;
    strobe(RW_READ, addr, 32'h0);
    for (int k = 1; k <= 11; k++) begin
      e_rd   = (k >= 4 && k <= 7);
      e_addr = e_rd ? base + 32'(4 * (k - 4)) : 32'h0;
      e_val  = (k >= 5 && k <= 8);
      e_ofs  = e_val ? 2'(k - 5) : 2'd0;
      e_data = e_val ? (32'hC0DE_0000 ^ (base + 32'(4 * (k - 5)))) : 32'h0;
      e_up   = (k == 8);
      n_cmp++;
      if (MemRead !== e_rd) begin
        n_err++; $display("[TB] FAIL read.MemRead T+%0d got %b want %b", k, MemRead, e_rd);
      end
      n_cmp++;
      if (MemAddr !== e_addr) begin
        n_err++; $display("[TB] FAIL read.MemAddr T+%0d got %h want %h", k, MemAddr, e_addr);
      end
      n_cmp++;
      if ({SysRValid, SysROffset} !== {e_val, e_ofs}) begin
        n_err++; $display("[TB] FAIL read.valid_ofs T+%0d got %b/%0d want %b/%0d", k, SysRValid, SysROffset, e_val, e_ofs);
      end
      n_cmp++;
      if (SysRData !== e_data) begin
        n_err++; $display("[TB] FAIL read.SysRData T+%0d got %h want %h", k, SysRData, e_data);
      end
      n_cmp++;
      if ({readup, SysReady, MemWrite} !== {e_up, 2'b00}) begin
        n_err++; $display("[TB] FAIL read.readup_ready_wr T+%0d got %b want %b00", k, {readup, SysReady, MemWrite}, e_up);
      end
      tick();
    end
  endtask

  task automatic test_write();
    logic e_wr, e_rdy;
    strobe(RW_WRITE, 32'h0000_0088, 32'hDEAD_BEEF);
    for (int k = 1; k <= 6; k++) begin
      e_wr  = (k == 3);
      e_rdy = (k == 4);
      n_cmp++;
      if (MemWrite !== e_wr) begin
        n_err++; $display("[TB] FAIL write.MemWrite T+%0d got %b want %b", k, MemWrite, e_wr);
      end
      n_cmp++;
      if ({MemAddr, MemWData} !== (e_wr ? {32'h0000_0088, 32'hDEAD_BEEF} : 64'h0)) begin
        n_err++; $display("[TB] FAIL write.addr_data T+%0d got %h/%h", k, MemAddr, MemWData);
      end
      n_cmp++;
      if (SysReady !== e_rdy) begin
        n_err++; $display("[TB] FAIL write.SysReady T+%0d got %b want %b", k, SysReady, e_rdy);
      end
      n_cmp++;
      if ({SysRValid, readup, MemRead} !== 3'b000) begin
        n_err++; $display("[TB] FAIL write.no_read T+%0d got %b want 000", k, {SysRValid, readup, MemRead});
      end
      tick();
    end
    n_cmp++;
    if (ProtoErr !== 1'b0) begin
      n_err++; $display("[TB] FAIL write.ProtoErr got %b want 0", ProtoErr);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    strobe(RW_READ, 32'h0000_2008, 32'h0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 10) begin
        SysStrobe = 1'b1; SysRW = RW_WRITE; SysAddr = 32'h0000_0102; SysWData = 32'h1234_5678;
      end else begin
        SysStrobe = 1'b0;
      end
      if (SysRValid) begin
        n_cmp++;
        if (SysRData !== (32'hC0DE_2000 ^ 32'(4 * nvalid))) begin
          n_err++; $display("[TB] FAIL b2b.SysRData T+%0d got %h", k, SysRData);
        end
        nvalid++;
      end
      n_cmp++;
      if (readup !== (k == 8)) begin
        n_err++; $display("[TB] FAIL b2b.readup T+%0d got %b want %b", k, readup, k == 8);
      end
      n_cmp++;
      if ({MemWrite, MemAddr, MemWData} !== ((k == 13) ? {1'b1, 32'h0000_0100, 32'h1234_5678}
                                           : (MemRead ? {1'b0, MemAddr, 32'h0} : 65'h0))) begin
        n_err++; $display("[TB] FAIL b2b.write T+%0d got %b %h %h", k, MemWrite, MemAddr, MemWData);
      end
      n_cmp++;
      if (SysReady !== (k == 14)) begin
        n_err++; $display("[TB] FAIL b2b.SysReady T+%0d got %b want %b", k, SysReady, k == 14);
      end
      tick();
    end
    SysStrobe = 1'b0;
    n_cmp++;
    if (nvalid !== 4) begin
      n_err++; $display("[TB] FAIL b2b.word_count got %0d want 4", nvalid);
    end
    n_cmp++;
    if (ProtoErr !== 1'b0) begin
      n_err++; $display("[TB] FAIL b2b.ProtoErr got %b want 0", ProtoErr);
    end
  endtask

  task automatic test_busy_strobe();
    logic e_val;
    strobe(RW_READ, 32'h0000_1234, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) begin
        SysStrobe = 1'b1; SysRW = RW_WRITE; SysAddr = 32'h0000_0088; SysWData = 32'h0BAD_0BAD;
      end else begin
        SysStrobe = 1'b0;
      end
      e_val = (k >= 5 && k <= 8);
      n_cmp++;
      if ({SysRValid, SysROffset, SysRData} !==
          (e_val ? {1'b1, 2'(k - 5), 32'hC0DE_1230 + 32'(4 * (k - 5))} : 35'h0)) begin
        n_err++; $display("[TB] FAIL busy.burst T+%0d got %b %0d %h", k, SysRValid, SysROffset, SysRData);
      end
      n_cmp++;
      if ({readup, MemWrite, SysReady} !== {k == 8, 2'b00}) begin
        n_err++; $display("[TB] FAIL busy.ctrl T+%0d got %b want %b00", k, {readup, MemWrite, SysReady}, k == 8);
      end
      n_cmp++;
      if (ProtoErr !== (k >= 6)) begin
        n_err++; $display("[TB] FAIL busy.ProtoErr T+%0d got %b want %b", k, ProtoErr, k >= 6);
      end
      tick();
    end
    SysStrobe = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if ({ProtoErr, MemWrite, SysReady} !== 3'b100) begin
      n_err++; $display("[TB] FAIL busy.sticky got %b want 100", {ProtoErr, MemWrite, SysReady});
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [135:0] all_out;
    strobe(RW_READ, 32'h0000_1234, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      if (k >= 5) begin
        n_cmp++;
        if ({SysRValid, SysROffset} !== {1'b1, 2'(k - 5)}) begin
          n_err++; $display("[TB] FAIL midrst.pre_words T+%0d got %b/%0d", k, SysRValid, SysROffset);
        end
      end
      if (k < 6) tick();
    end
    #2;
    reset = 1'b0;
    #1;
    all_out = {SysReady, SysRValid, readup, MemRead, MemWrite, ProtoErr,
               SysROffset, SysRData, MemAddr, MemWData, 32'h0};
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("[TB] FAIL midrst.async_clear got %h want 0", all_out);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({SysRValid, readup, MemRead} !== 3'b000) begin
        n_err++; $display("[TB] FAIL midrst.no_resume got %b want 000", {SysRValid, readup, MemRead});
      end
    end
    test_read_fill(32'h0000_1234, 32'h0000_1230);
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_read_fill(32'h0000_1234, 32'h0000_1230);
    test_write();
    tick();
    test_back_to_back();
    tick();
    test_busy_strobe();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
